note_lane: RTL

Chart sequencer and hit judge for the drum lane. It fetches notes from a synchronous chart ROM and scrolls a window of note slots one position per beat. It presents the window as `red_sequence` and `yellow_sequence` to the 10-square lane renderer directly downstream. It judges player hits against the judgment slot and keeps score and combo.

---
 rtl/tatsujin_pkg.sv | 22 ++
 rtl/sat_counter8.sv | 23 ++
 rtl/note_lane.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tatsujin_pkg.sv
// Shared definitions for the drum-lane blocks.
//   NOTE_*        : 2-bit chart entry encoding (none / red / yellow / end-of-song)
//   state_t       : sequencer state
//   SLOTS_DEFAULT : default window length in slots
package tatsujin_pkg;

    localparam logic [1:0] NOTE_NONE   = 2'b00;
    localparam logic [1:0] NOTE_RED    = 2'b01;
    localparam logic [1:0] NOTE_YELLOW = 2'b10;
    localparam logic [1:0] NOTE_END    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRIME,
        ST_PLAY,
        ST_DONE
    } state_t;

    localparam int SLOTS_DEFAULT = 10;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit counter that saturates at 255.
//   clk   : system clock
//   reset : synchronous, active-high clear
//   clear : synchronous clear, wins over inc
//   inc   : add one unless already at 255
//   count : registered count value
module sat_counter8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/note_lane.sv
// Chart sequencer and hit judge for the drum lane.
// Fetches notes from a synchronous chart ROM, scrolls a window of note slots
// one position per beat_tick, judges hits against slot 0 and keeps
// score/combo.
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin play from IDLE or DONE
//   beat_tick        : one scroll step
//   hit_red/yellow   : edge-detected key pulses
//   chart_addr/data  : ROM address out, ROM data in (one cycle latency)
//   red/yellow_sequence : window, bit 0 is the judgment slot
//   seq_valid        : pulse after each window update
//   score, combo     : saturating counters
//   playing, done    : state flags
module note_lane
    import tatsujin_pkg::*;
#(
    parameter int SLOTS  = SLOTS_DEFAULT,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              beat_tick,
    input  logic              hit_red,
    input  logic              hit_yellow,
    output logic [ADDR_W-1:0] chart_addr,
    input  logic [1:0]        chart_data,
    output logic [SLOTS-1:0]  red_sequence,
    output logic [SLOTS-1:0]  yellow_sequence,
    output logic              seq_valid,
    output logic [7:0]        score,
    output logic [7:0]        combo,
    output logic              playing,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t           state;
    logic [1:0]       next_note;
    logic             end_seen;
    logic             load_pending;

    logic             in_play;
    logic             start_go;
    logic             red_ok;
    logic             red_wrong;
    logic             yellow_ok;
    logic             yellow_wrong;
    logic             miss;
    logic             score_inc;
    logic             combo_clr;
    logic             end_path;
    logic             end_next;
    logic             red_in;
    logic             yellow_in;
    logic [SLOTS-1:0] red_kept;
    logic [SLOTS-1:0] yellow_kept;
    logic [SLOTS-1:0] red_shift;
    logic [SLOTS-1:0] yellow_shift;

    always_comb begin
        in_play      = (state == ST_PLAY);
        start_go     = start && ((state == ST_IDLE) || (state == ST_DONE));
        red_ok       = in_play && hit_red    &&  red_sequence[0];
        red_wrong    = in_play && hit_red    && !red_sequence[0];
        yellow_ok    = in_play && hit_yellow &&  yellow_sequence[0];
        yellow_wrong = in_play && hit_yellow && !yellow_sequence[0];
        // A note sitting in slot 0 when the beat moves it out is a miss,
        // unless a hit in this same cycle already took it.
        miss         = in_play && beat_tick &&
                       ((red_sequence[0] && !hit_red) ||
                        (yellow_sequence[0] && !hit_yellow));
        score_inc    = red_ok || yellow_ok;
        combo_clr    = start_go || red_wrong || yellow_wrong || miss;

        // Hits are judged against the pre-shift window; a hit note is
        // removed before the shift so it never counts as a miss.
        red_kept     = red_sequence    & ~{{(SLOTS-1){1'b0}}, red_ok};
        yellow_kept  = yellow_sequence & ~{{(SLOTS-1){1'b0}}, yellow_ok};

        end_path     = (next_note == NOTE_END) || end_seen;
        red_in       = !end_path && (next_note == NOTE_RED);
        yellow_in    = !end_path && (next_note == NOTE_YELLOW);
        red_shift    = {red_in,    red_kept[SLOTS-1:1]};
        yellow_shift = {yellow_in, yellow_kept[SLOTS-1:1]};
        // An address wrap without an end marker also ends the song.
        end_next     = end_path || (&chart_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            chart_addr      <= '0;
            next_note       <= NOTE_NONE;
            end_seen        <= 1'b0;
            load_pending    <= 1'b0;
            red_sequence    <= '0;
            yellow_sequence <= '0;
            seq_valid       <= 1'b0;
            playing         <= 1'b0;
            done            <= 1'b0;
        end else begin
            seq_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        red_sequence    <= '0;
                        yellow_sequence <= '0;
                        end_seen        <= 1'b0;
                        next_note       <= NOTE_NONE;
                        load_pending    <= 1'b0;
                        chart_addr      <= '0;
                        playing         <= 1'b0;
                        done            <= 1'b0;
                        state           <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_PRIME;
                end
                ST_PRIME: begin
                    next_note  <= chart_data;
                    chart_addr <= chart_addr + ADDR_ONE;
                    playing    <= 1'b1;
                    state      <= ST_PLAY;
                end
                ST_PLAY: begin
                    // ROM data for the address issued on the last beat
                    // arrives one cycle after that beat.
                    if (load_pending) begin
                        next_note    <= chart_data;
                        load_pending <= 1'b0;
                    end
                    if (beat_tick) begin
                        red_sequence    <= red_shift;
                        yellow_sequence <= yellow_shift;
                        seq_valid       <= 1'b1;
                        if (end_path) begin
                            end_seen <= 1'b1;
                        end else begin
                            chart_addr   <= chart_addr + ADDR_ONE;
                            load_pending <= 1'b1;
                            if (&chart_addr) begin
                                end_seen <= 1'b1;
                            end
                        end
                        if (end_next && (red_shift == '0) && (yellow_shift == '0)) begin
                            playing <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end else if (red_ok || yellow_ok) begin
                        red_sequence    <= red_kept;
                        yellow_sequence <= yellow_kept;
                        seq_valid       <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter8 u_score (
        .clk   (clk),
        .reset (reset),
        .clear (start_go),
        .inc   (score_inc),
        .count (score)
    );

    sat_counter8 u_combo (
        .clk   (clk),
        .reset (reset),
        .clear (combo_clr),
        .inc   (score_inc),
        .count (combo)
    );

endmodule
